// File: rtl/uart_pkg.sv
// Shared UART definitions: line state encoding, frame constants and a
// parity helper. Used by the transmitter and by a future receiver.
package uart_pkg;

   // Line-level FSM states. PARITY is only reachable when UART_PARITY_EN is defined.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam int   DATA_BITS   = 8;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;
   localparam logic IDLE_LEVEL  = 1'b1;

   // Even parity bit: XOR of all data bits.
   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer. Counts 0..CyclesPerBit-1 and raises tick for one cycle
// at the last count, then wraps. clear holds the counter at zero so every
// bit period starts aligned to the cycle after clear drops.
module uart_baud_tick #(
   parameter int CyclesPerBit = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int                CntW = (CyclesPerBit > 1) ? $clog2(CyclesPerBit) : 1;
   localparam logic [CntW-1:0]   LAST = CntW'(CyclesPerBit - 1);

   logic [CntW-1:0] cnt;

   assign tick = (cnt == LAST);

   // Free-running bit-period counter, held at zero while cleared.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: accepts a byte on a valid/ready handshake and sends it
// as 8N1, LSB first, on a registered TX line that idles high.
// Build option: define UART_PARITY_EN to insert an even-parity bit between
// the last data bit and the stop bit (frame becomes 11 bit periods).
//
// Handshake: a byte transfers on a rising edge where DataInValid and
// DataInReady are both 1. DataInReady is decoded from registered state only
// (high exactly in IDLE), so it never depends on DataInValid. A valid
// presented while not ready is ignored; there is no buffering.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int ClockFreq = 100_000_000,
   parameter int BaudRate  = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] DataIn,
   input  logic       DataInValid,
   output logic       DataInReady,
   output logic       SOut
);

   localparam int CyclesPerBit = ClockFreq / BaudRate;
   localparam int BitCntW      = $clog2(DATA_BITS);

   generate
      if (CyclesPerBit < 2) begin : g_bad_baud
         $error("uart_transmitter: ClockFreq/BaudRate must be at least 2");
      end
   endgenerate

   uart_state_t              state;
   logic [DATA_BITS-1:0]     shift;
   logic [BitCntW-1:0]       bit_cnt;
   logic                     bit_tick;
   logic                     baud_clear;
`ifdef UART_PARITY_EN
   logic                     parity;
`endif

   // Bit timing restarts from zero whenever the line is idle.
   assign baud_clear  = (state == IDLE);
   assign DataInReady = (state == IDLE);

   uart_baud_tick #(
      .CyclesPerBit (CyclesPerBit)
   ) u_baud_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (baud_clear),
      .tick  (bit_tick)
   );

   // Frame sequencer; SOut is registered and always set to the level of the
   // state being entered, so the line changes on the same edge as the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         SOut    <= IDLE_LEVEL;
         shift   <= '0;
         bit_cnt <= '0;
`ifdef UART_PARITY_EN
         parity  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               SOut <= IDLE_LEVEL;
               if (DataInValid) begin
                  shift <= DataIn;
`ifdef UART_PARITY_EN
                  parity <= even_parity(DataIn);
`endif
                  state <= START;
                  SOut  <= START_LEVEL;
               end
            end
            START: begin
               if (bit_tick) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  SOut    <= shift[0];
               end
            end
            DATA: begin
               if (bit_tick) begin
                  shift   <= {1'b0, shift[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == BitCntW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                     state <= PARITY;
                     SOut  <= parity;
`else
                     state <= STOP;
                     SOut  <= STOP_LEVEL;
`endif
                  end else begin
                     SOut <= shift[1];
                  end
               end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
               if (bit_tick) begin
                  state <= STOP;
                  SOut  <= STOP_LEVEL;
               end
            end
`endif
            STOP: begin
               if (bit_tick) begin
                  state <= IDLE;
                  SOut  <= IDLE_LEVEL;
               end
            end
            default: begin
               state <= IDLE;
               SOut  <= IDLE_LEVEL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at ClockFreq=1000, BaudRate=100
// (10 cycles per bit). Expected line levels are queued per clock cycle at
// each handshake and compared on the falling edge by a monitor.
module tb_uart_transmitter;

   localparam int CPB = 10;
`ifdef UART_PARITY_EN
   localparam int FRAME_CYC = 11 * CPB;
`else
   localparam int FRAME_CYC = 10 * CPB;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       data_valid = 1'b0;
   logic       data_ready;
   logic       s_out;

   always #5 clk = ~clk;

   uart_transmitter #(
      .ClockFreq (1000),
      .BaudRate  (100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .DataIn      (data_in),
      .DataInValid (data_valid),
      .DataInReady (data_ready),
      .SOut        (s_out)
   );

   // Vector: byte, line levels start..stop in time order (MSB sent first,
   // parity excluded), and the expected even-parity bit.
   typedef struct {
      logic [7:0] data;
      logic [9:0] frame10;
      logic       par;
   } vec_t;

   vec_t vecs[8];

   logic [0:0] exp_q[$];
   int check_cnt = 0;
   int fail_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Per-cycle waveform monitor.
   always @(negedge clk) begin : mon
      logic [0:0] e;
      if (rst && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("sout_wave", 32'(s_out), 32'(e));
      end
   end

   task automatic push_level(input logic b, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(b);
   endtask

   // Whole frame plus one idle cycle (the cycle in which the next handshake
   // can be sampled at the earliest).
   task automatic push_frame(input logic [9:0] f10, input logic par);
      for (int i = 9; i >= 1; i--) push_level(f10[i], CPB);
`ifdef UART_PARITY_EN
      push_level(par, CPB);
`else
      if (par === 1'bx) check("par_const", 32'(par), 32'd0);
`endif
      push_level(f10[0], CPB);
      push_level(1'b1, 1);
   endtask

   // Wait (bounded) for ready, present the byte for one cycle, queue expectations.
   task automatic handshake(input logic [7:0] d, input logic [9:0] f10, input logic par);
      int n = 0;
      while (!data_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("ready_timeout", 32'(data_ready), 32'd1);
      data_in    = d;
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      push_frame(f10, par);
   endtask

   // Handshake, then measure cycles until ready returns while scrambling DataIn.
   task automatic run_frame(input logic [7:0] d, input logic [9:0] f10, input logic par);
      int k = 0;
      handshake(d, f10, par);
      do begin
         @(negedge clk);
         k++;
         if (k == 1) check("ready_low", 32'(data_ready), 32'd0);
         data_in = 8'($urandom_range(0, 255));
      end while (!data_ready && k <= 300);
      check("frame_len", 32'(k - 1), 32'(FRAME_CYC));
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int rst_pts[2];
      vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
      vecs[1] = '{8'h3C, 10'b0001111001, 1'b0};
      vecs[2] = '{8'h00, 10'b0000000001, 1'b0};
      vecs[3] = '{8'hFF, 10'b0111111111, 1'b0};
      vecs[4] = '{8'h55, 10'b0101010101, 1'b0};
      vecs[5] = '{8'h07, 10'b0111000001, 1'b1};
      vecs[6] = '{8'h03, 10'b0110000001, 1'b0};
      vecs[7] = '{8'h80, 10'b0000000011, 1'b1};
      rst_pts[0] = 35;
      rst_pts[1] = 5;

      // Reset and quiet idle line.
      repeat (3) @(negedge clk);
      check("rst_sout", 32'(s_out), 32'd1);
      check("rst_ready", 32'(data_ready), 32'd1);
      rst = 1'b1;
      push_level(1'b1, 50);
      wait_drain();

      // Table: every entry handshakes in the first idle cycle after the last.
      for (int i = 0; i < 8; i++) begin
         run_frame(vecs[i].data, vecs[i].frame10, vecs[i].par);
      end
      wait_drain();

      // Dropped write mid-frame: 0xFF must never reach the line.
      handshake(8'h3C, 10'b0001111001, 1'b0);
      repeat (39) @(negedge clk);
      check("drop_ready", 32'(data_ready), 32'd0);
      data_in    = 8'hFF;
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      wait_drain();
      push_level(1'b1, 20);
      wait_drain();

      // Back-to-back 0x00 then 0xFF: low 90, high 10 + handshake cycle, low 10, high 90.
      run_frame(8'h00, 10'b0000000001, 1'b0);
      run_frame(8'hFF, 10'b0111111111, 1'b0);
      wait_drain();

      // Asynchronous reset mid-frame, then a clean frame.
      for (int r = 0; r < 2; r++) begin
         handshake(8'h55, 10'b0101010101, 1'b0);
         repeat (rst_pts[r]) @(negedge clk);
         #2;
         rst = 1'b0;
         #1;
         check("async_rst_sout", 32'(s_out), 32'd1);
         check("async_rst_ready", 32'(data_ready), 32'd1);
         exp_q.delete();
         repeat (2) @(negedge clk);
         rst = 1'b1;
         push_level(1'b1, 5);
         wait_drain();
         run_frame(8'h81, 10'b0100000011, 1'b0);
         wait_drain();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
      $finish;
   end

endmodule
